// File: rtl/voice_mixer_pkg.sv
// Shared types, constants and helper functions for the voice mixer.
package voice_mixer_pkg;

    localparam int NUM_VOICES_DEFAULT = 8;

    typedef logic [15:0] freq_t;
    typedef logic [31:0] volume_t;
    typedef logic [16:0] gain_t;

    localparam volume_t VOLUME_UNITY = 32'h0010_0000;
    localparam gain_t   GAIN_UNITY   = 17'h0_8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } mix_state_t;

    // Clamp a 20-bit signed value to the signed 16-bit PCM range.
    function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
        logic signed [15:0] r;
        if (v > 20'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -20'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Volume to gain: anything at or above unity saturates to unity.
    function automatic gain_t target_gain(input volume_t vol);
        gain_t r;
        if (vol >= VOLUME_UNITY) begin
            r = GAIN_UNITY;
        end else begin
            r = {1'b0, vol[20:5]};
        end
        return r;
    endfunction

    // Move cur toward tgt by at most step.
    function automatic gain_t ramp_toward(input gain_t cur, input gain_t tgt, input gain_t step);
        gain_t r;
        if (tgt > cur) begin
            if ((tgt - cur) > step) begin
                r = cur + step;
            end else begin
                r = tgt;
            end
        end else if (cur > tgt) begin
            if ((cur - tgt) > step) begin
                r = cur - step;
            end else begin
                r = tgt;
            end
        end else begin
            r = cur;
        end
        return r;
    endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Voice mixer bus: per-voice pitch/volume in, mixed PCM sample out.
interface voice_mixer_if
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT
);
    freq_t   [NUM_VOICES-1:0] frequencies;
    volume_t [NUM_VOICES-1:0] voice_volumes;
    logic signed [15:0]       sample_out;
    logic                     sample_valid;

    // The allocator side drives voice parameters and consumes samples.
    modport master (
        output frequencies,
        output voice_volumes,
        input  sample_out,
        input  sample_valid
    );

    // The mixer side consumes voice parameters and produces samples.
    modport slave (
        input  frequencies,
        input  voice_volumes,
        output sample_out,
        output sample_valid
    );
endinterface

// File: rtl/voice_mixer_osc.sv
// Combinational sawtooth oscillator slice, shared by all voice slots.
module voice_osc
    import voice_mixer_pkg::*;
#(
    parameter int PHASE_MULT = 2796
) (
    input  logic [31:0]        phase_i,
    input  freq_t              freq_i,
    input  gain_t              gain_i,
    output logic [31:0]        next_phase_o,
    output logic signed [16:0] contrib_o
);
    logic signed [15:0] wave_s;
    logic signed [17:0] gain_sx_s;
    logic signed [33:0] prod_s;
    logic signed [33:0] prod_shr_s;
    logic [31:0]        inc_s;

    // Wave from the pre-update phase, scaled by gain; phase advances modulo 2^32.
    always_comb begin
        wave_s       = $signed(phase_i[31:16]);
        gain_sx_s    = $signed({1'b0, gain_i});
        prod_s       = 34'(wave_s) * 34'(gain_sx_s);
        prod_shr_s   = prod_s >>> 15;
        contrib_o    = 17'(prod_shr_s);
        inc_s        = 32'(freq_i) * 32'(PHASE_MULT);
        next_phase_o = phase_i + inc_s;
    end
endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed sawtooth voice mixer: one voice per clock, one sample per tick.
// Optional feature macro: VOICE_MIXER_RAMP_EN (per-voice gain ramp for de-clicking).
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int CLK_DIV    = 1042,
    parameter int PHASE_MULT = 2796,
    parameter int MIX_SHIFT  = 2,
    parameter int RAMP_STEP  = 1024
) (
    input  logic         clk,
    input  logic         reset,
    voice_mixer_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    // Static parameter sanity: the sweep must finish before the next tick.
    if ((CLK_DIV < NUM_VOICES + 2) || (RAMP_STEP < 1) || (RAMP_STEP > 32768)) begin : g_param_check
        $error("voice_mixer: illegal parameter combination");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick_s;
    mix_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic signed [19:0] acc_q, acc_d;
    logic [31:0]        phase_q [NUM_VOICES];
    logic signed [15:0] sample_out_q, sample_out_d;
    logic               sample_valid_q, sample_valid_d;

    logic               acc_clr_s;
    logic               sweep_s;
    logic               sample_load_s;
    freq_t              freq_sel_s;
    volume_t            vol_sel_s;
    logic [31:0]        phase_sel_s;
    gain_t              tgt_gain_s;
    gain_t              mul_gain_s;
    logic [31:0]        next_phase_s;
    logic signed [16:0] contrib_s;
    logic signed [19:0] acc_shr_s;

    // Sample-rate divider; the wrap cycle is the tick.
    always_comb begin
        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= {DIV_W{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    // Sweep sequencer: wait for tick, walk every voice slot, then publish.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_clr_s     = 1'b0;
        sweep_s       = 1'b0;
        sample_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    acc_clr_s = 1'b1;
                    idx_d     = {IDX_W{1'b0}};
                    state_d   = SWEEP;
                end else begin
                    state_d   = IDLE;
                end
            end
            SWEEP: begin
                sweep_s = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SWEEP;
                end
            end
            DONE: begin
                sample_load_s = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and slot index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Select the live inputs and phase of the voice in the current slot.
    always_comb begin
        freq_sel_s  = bus.frequencies[idx_q];
        vol_sel_s   = bus.voice_volumes[idx_q];
        phase_sel_s = phase_q[idx_q];
        tgt_gain_s  = target_gain(vol_sel_s);
    end

`ifdef VOICE_MIXER_RAMP_EN
    localparam gain_t RAMP_STEP_G = gain_t'(RAMP_STEP);

    gain_t cur_gain_q [NUM_VOICES];

    // Ramped gain for this slot; the multiply sees the post-step value.
    always_comb begin
        mul_gain_s = ramp_toward(cur_gain_q[idx_q], tgt_gain_s, RAMP_STEP_G);
    end

    // Per-voice ramp gain registers, stepped once per sample in their slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                cur_gain_q[v] <= 17'h0_0000;
            end
        end else begin
            if (sweep_s) begin
                cur_gain_q[idx_q] <= mul_gain_s;
            end
        end
    end
`else
    // Without ramping the target gain is applied immediately.
    always_comb begin
        mul_gain_s = tgt_gain_s;
    end
`endif

    voice_osc #(
        .PHASE_MULT (PHASE_MULT)
    ) u_osc (
        .phase_i      (phase_sel_s),
        .freq_i       (freq_sel_s),
        .gain_i       (mul_gain_s),
        .next_phase_o (next_phase_s),
        .contrib_o    (contrib_s)
    );

    // Accumulator next value: clear on tick, add one voice per sweep slot.
    always_comb begin
        if (acc_clr_s) begin
            acc_d = 20'sd0;
        end else if (sweep_s) begin
            acc_d = acc_q + 20'(contrib_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and per-voice phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 20'sd0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= 32'h0000_0000;
            end
        end else begin
            acc_q <= acc_d;
            if (sweep_s) begin
                phase_q[idx_q] <= next_phase_s;
            end
        end
    end

    // Scale and saturate the finished mix; strobe valid alongside the new sample.
    always_comb begin
        acc_shr_s = acc_q >>> MIX_SHIFT;
        if (sample_load_s) begin
            sample_out_d = sat16(acc_shr_s);
        end else begin
            sample_out_d = sample_out_q;
        end
        sample_valid_d = sample_load_s;
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out_q   <= 16'sd0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
endmodule
